// File: rtl/mem_bus_arbiter.sv
// Two-master data-bus arbiter: registered grant, fixed priority to master 0.
// Optional master-1 starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              stall0,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   starve_hit;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("mem_bus_arbiter: STARVE_LIMIT must be in 1..255");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] wait1;

    // Counts cycles master 1 has been kept waiting; saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait1 <= '0;
        end else if (state == G1 || !req1) begin
            wait1 <= '0;
        end else if (wait1 != 8'hFF) begin
            wait1 <= wait1 + 8'd1;
        end
    end

    assign starve_hit = (wait1 >= 8'(STARVE_LIMIT));
`else
    assign starve_hit = 1'b0;
`endif

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = IDLE;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;

        if (req0 && req1) begin
            state_nxt = starve_hit ? G1 : G0;
        end else if (req0) begin
            state_nxt = G0;
        end else if (req1) begin
            state_nxt = G1;
        end

        // Write wins when rd and wr are both set; req with no strobe is a null cycle.
        unique case (state)
            G0: begin
                ack0      = req0;
                rdata0    = bus_rdata;
                bus_addr  = addr0;
                bus_wdata = wdata0;
                bus_wr    = req0 & wr0;
                bus_rd    = req0 & rd0 & ~wr0;
            end
            G1: begin
                ack1      = req1;
                rdata1    = bus_rdata;
                bus_addr  = addr1;
                bus_wdata = wdata1;
                bus_wr    = req1 & wr1;
                bus_rd    = req1 & rd1 & ~wr1;
            end
            default: ;
        endcase
    end

    // Depends only on req0 and the registered state, never on req1.
    assign stall0 = req0 & ~((state == G0) & req0);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the single data-memory/peripheral bus between the pipeline core and the peripheral block. Master 0 is the core data port; master 1 is an auxiliary master (UART loader / DMA). The arbiter registers a grant each cycle, muxes the granted master onto the bus, returns read data and a one-cycle acknowledge, and stalls the losing master. Fixed priority to master 0, with an optional starvation guard for master 1.

## Interface
- STARVE_LIMIT, 8: cycles master 1 may wait with `req1` high before it takes priority (guard build only); legal range 1..255.
- ADDR_W, 32: bus address width.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  master request; held high until the matching ack.
- rd0, wr0 / rd1, wr1  in  1  read / write strobes; qualified by req.
- addr0 / addr1  in  ADDR_W  master address.
- wdata0 / wdata1  in  32  master write data.
- ack0 / ack1  out  1  transaction accepted this cycle; read data valid this cycle.
- rdata0 / rdata1  out  32  read data returned to the master.
- stall0  out  1  `req0 & ~ack0`; feeds the core's pipeline hold.
- bus_rd, bus_wr  out  1  slave strobes.
- bus_addr  out  ADDR_W  slave address.
- bus_wdata  out  32  slave write data.
- bus_rdata  in  32  slave read data; combinational, same cycle as `bus_rd`.

## Operation
- States: IDLE, G0, G1, held in a 2-bit registered state.
- Next-state logic runs every cycle and uses the current `req0` / `req1`:
  - neither request: IDLE.
  - only one request: grant that master (G0 or G1).
  - both requests: G0, except G1 when `starve_hit` is set.
- A master that was just acked and still holds `req` high is issuing a new transaction and is arbitrated normally. This allows back-to-back accesses.
- In Gx:
  - `bus_*` are driven from master x.
  - `ackx = reqx`.
  - `rdatax = bus_rdata`.
  - The other master sees ack 0 and rdata 0.
- In Gx with `reqx` low (request withdrawn): bus strobes are 0, no ack.
- In IDLE: `bus_rd`, `bus_wr`, `bus_addr`, `bus_wdata` are all 0.
- `rd` and `wr` both high: treated as a write, `bus_rd` forced 0.
- `req` high with neither `rd` nor `wr`: acked as a null cycle, no strobe.
- Starvation counter `wait1`, 8 bits, saturating:
  - increments when `req1` is high and state is not G1.
  - clears when the state is G1 or `req1` is low.
  - `starve_hit = (wait1 >= STARVE_LIMIT)`.

## Timing
- Reset values: state IDLE, `wait1` 0, every output 0.
- Reset asserted mid-transaction:
  - bus strobes and acks drop immediately, without waiting for a clock edge.
  - the interrupted transaction is lost; the master must reissue it.
- Latency from a request rising (seen at edge n) to its ack:
  - minimum 1 cycle: state registered at edge n, ack during cycle n+1.
  - a master that keeps `req` high gets sustained throughput of one transaction per cycle.
- Write commits at the clock edge that ends the ack cycle.
- Read data is valid only while the ack is high; the master samples it at that same edge.
- Grant switches take effect on the edge with no dead cycle; a G0→G1 switch is legal on consecutive cycles.
- `stall0` is combinational from `req0` and the registered state; there is no combinational path from `req1` to `stall0`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - `wait1` counter and `starve_hit` are built.
  - Master 1 is guaranteed a grant within STARVE_LIMIT+1 cycles of raising `req1`.
- `ARB_STARVE_GUARD_EN` undefined:
  - no counter is built and `starve_hit` is tied 0.
  - Strict master-0 priority; master 1 can starve indefinitely while `req0` stays high.

## Test plan
- Reset then idle: all outputs 0. Raise `req0` (rd, addr 0x40000010) at edge 1 → state G0, `ack0` = 1 in cycle 2, `rdata0` = `bus_rdata` = 0x000000A5, `stall0` = 0 in cycle 2.
- Write by master 1 alone (addr 0x00000100, data 0xDEADBEEF) → `bus_wr` = 1 with that addr/data for exactly one cycle, `ack1` = 1, `ack0` = 0.
- Both request simultaneously for one transaction each → G0 then G1 on consecutive cycles. `ack0` in cycle n+1, `ack1` in cycle n+2; `stall0` = 1 only in cycle n.
- Guard built, STARVE_LIMIT = 4, `req0` held high continuously, `req1` raised at cycle 0:
  - `ack1` within 5 cycles.
  - `stall0` = 1 during that ack cycle.
  - `wait1` returns to 0.
- Guard not built, same stimulus for 50 cycles → `ack1` never asserted, `ack0` every cycle.
- Asynchronous reset pulse mid-G1 write → `bus_wr` and `ack1` drop before the next edge. After release, state is IDLE, and the reissued write completes normally.
